pipe_ctrl_gen: RTL and testbench

Parametrised pipeline pause/flush controller, successor to the fixed 6-stage pause controller.
- Collects per-stage stall requests into a stall mask.
- Converts CP0 exception types into a flush plus a redirect PC, and can hold flush for several cycles.
- Watches for stalls that last too long and counts stall cycles for performance monitoring.
- Sits beside the pipeline and drives every stage register's stall/flush inputs and the PC redirect.

---
 rtl/pipe_ctrl_gen.sv | 183 ++++++++++++++++++
 tb/tb_pipe_ctrl_gen.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_gen.sv
// Purpose: pipeline stall/flush controller; builds a prefix stall mask, maps exceptions to flush + redirect PC,
//          flags over-long stalls and counts stalled cycles.
// Latency: stall/flush/new_pc/timeout are combinational from inputs + state; perf counter is registered (1 cycle).
// Backpressure: none; pure sideband controller, every output is valid every cycle.
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset (forces every output to 0)
//   i_stallreq[N_STAGE]     per-stage stall requests (bit k = stage k)
//   i_except_type[32]       exception code from MEM, 0 = none
//   i_cp0_epc[ADDR_W]       return address used for eret (0x0e)
//   i_perf_clr              synchronous clear of the stall cycle counter
//   o_stall[N_STAGE]        hold mask, always of the form 0..01..1
//   o_flush, o_new_pc       flush all stages and redirect fetch; new_pc is 0 whenever flush is 0
//   o_stall_timeout         one-cycle pulse on the STALL_TIMEOUT-th consecutive stall cycle
//   o_perf_stall_cycles     saturating count of cycles with any stall bit set
module pipe_ctrl_gen #(
    parameter int                N_STAGE       = 6,
    parameter int                ADDR_W        = 32,
    parameter logic [ADDR_W-1:0] INT_VEC       = 'h0000_0020,
    parameter logic [ADDR_W-1:0] EXC_VEC       = 'h0000_0040,
    parameter int                FLUSH_CYCLES  = 1,
    parameter int                STALL_TIMEOUT = 1023,
    parameter int                CNT_W         = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_STAGE-1:0] i_stallreq,
    input  logic [31:0]        i_except_type,
    input  logic [ADDR_W-1:0]  i_cp0_epc,
    input  logic               i_perf_clr,
    output logic [N_STAGE-1:0] o_stall,
    output logic               o_flush,
    output logic [ADDR_W-1:0]  o_new_pc,
    output logic               o_stall_timeout,
    output logic [CNT_W-1:0]   o_perf_stall_cycles
);

    // The exception cycle itself is the first flush cycle, so FLUSH only covers the remainder.
    localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);
    localparam logic [3:0] FC_INIT     = 4'(FLUSH_CYCLES - 1);
    localparam bit         TO_EN       = (STALL_TIMEOUT != 0);
    localparam logic [15:0] TO_SAT     = 16'(STALL_TIMEOUT);
    localparam logic [15:0] TO_LAST    = 16'(STALL_TIMEOUT - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          fcnt_q, fcnt_d;
    logic [ADDR_W-1:0]   pc_hold_q, pc_hold_d;
    logic [15:0]         tcnt_q;
    logic [CNT_W-1:0]    perf_q;

    logic                exc_vld;
    logic [ADDR_W-1:0]   exc_pc;
    logic [N_STAGE-1:0]  req_mask;
    logic                stall_act;

    assign exc_vld = |i_except_type;

    // Exception code to redirect target; unknown nonzero codes still flush but go to 0.
    always_comb begin
        exc_pc = '0;
        case (i_except_type)
            32'h0000_0001:                               exc_pc = INT_VEC;
            32'h0000_0008, 32'h0000_000a,
            32'h0000_000c, 32'h0000_000d:                exc_pc = EXC_VEC;
            32'h0000_000e:                               exc_pc = i_cp0_epc;
            default:                                     exc_pc = '0;
        endcase
    end

    // Stalling stage k must also hold every older-in-flow stage below it, so bit k is set
    // whenever any request at index >= k is present.
    always_comb begin
        req_mask = '0;
        for (int k = 0; k < N_STAGE; k++) begin
            req_mask[k] = |(i_stallreq >> k);
        end
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            fcnt_q    <= 4'd0;
            pc_hold_q <= '0;
        end else begin
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
            pc_hold_q <= pc_hold_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        pc_hold_d = pc_hold_q;
        case (state_q)
            IDLE: begin
                if (exc_vld) begin
                    pc_hold_d = exc_pc;
                    if (MULTI_FLUSH) begin
                        state_d = FLUSH;
                        fcnt_d  = FC_INIT;
                    end
                end
            end
            FLUSH: begin
                // New exceptions are ignored until the current flush finishes.
                if (fcnt_q == 4'd1) begin
                    state_d = IDLE;
                    fcnt_d  = 4'd0;
                end else begin
                    fcnt_d  = fcnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                fcnt_d  = 4'd0;
            end
        endcase
    end

    // Output logic; everything is forced low during reset, including the combinational paths.
    always_comb begin
        o_stall  = '0;
        o_flush  = 1'b0;
        o_new_pc = '0;
        if (!i_rst) begin
            case (state_q)
                IDLE: begin
                    if (exc_vld) begin
                        o_flush  = 1'b1;
                        o_new_pc = exc_pc;
                    end else begin
                        o_stall  = req_mask;
                    end
                end
                FLUSH: begin
                    o_flush  = 1'b1;
                    o_new_pc = pc_hold_q;
                end
                default: begin
                    o_flush  = 1'b0;
                end
            endcase
        end
    end

    // o_stall is already zero whenever o_flush is high.
    assign stall_act = |o_stall;

    // Consecutive-stall counter; saturates at the timeout so the pulse fires once per stall run.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tcnt_q <= 16'd0;
        end else if (!stall_act) begin
            tcnt_q <= 16'd0;
        end else if (tcnt_q != TO_SAT) begin
            tcnt_q <= tcnt_q + 16'd1;
        end
    end

    // Pulse during the stall cycle that carries tcnt to the timeout value.
    assign o_stall_timeout = TO_EN && stall_act && (tcnt_q == TO_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            perf_q <= '0;
        end else if (i_perf_clr) begin
            perf_q <= '0;
        end else if (stall_act && (perf_q != {CNT_W{1'b1}})) begin
            perf_q <= perf_q + CNT_W'(1);
        end
    end

    assign o_perf_stall_cycles = perf_q;

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Purpose: scoreboard bench for pipe_ctrl_gen; two instances (legacy defaults and a short-flush/short-timeout/narrow-counter
//          build) share one stimulus stream, a cycle-level reference model queues expectations, a monitor compares.
// Latency: expectations are queued just after each rising edge and compared on the following falling edge.
// Backpressure: not applicable; every output is compared every cycle.
module tb_pipe_ctrl_gen;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        tmo;
        logic [31:0] perf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stallreq = '0;
    logic [31:0] exc = '0;
    logic [31:0] epc = '0;
    logic        perf_clr = 1'b0;

    logic [5:0]  a_stall, b_stall;
    logic        a_flush, b_flush;
    logic [31:0] a_pc, b_pc;
    logic        a_tmo, b_tmo;
    logic [31:0] a_perf;
    logic [3:0]  b_perf;

    int total = 0;
    int bad   = 0;
    bit stim_done = 1'b0;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    pipe_ctrl_gen u_dut_a (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_stallreq          (stallreq),
        .i_except_type       (exc),
        .i_cp0_epc           (epc),
        .i_perf_clr          (perf_clr),
        .o_stall             (a_stall),
        .o_flush             (a_flush),
        .o_new_pc            (a_pc),
        .o_stall_timeout     (a_tmo),
        .o_perf_stall_cycles (a_perf)
    );

    pipe_ctrl_gen #(
        .FLUSH_CYCLES  (3),
        .STALL_TIMEOUT (4),
        .CNT_W         (4)
    ) u_dut_b (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_stallreq          (stallreq),
        .i_except_type       (exc),
        .i_cp0_epc           (epc),
        .i_perf_clr          (perf_clr),
        .o_stall             (b_stall),
        .o_flush             (b_flush),
        .o_new_pc            (b_pc),
        .o_stall_timeout     (b_tmo),
        .o_perf_stall_cycles (b_perf)
    );

    // ---------------- reference model ----------------
    // Per-instance configuration: flush length, timeout threshold, counter ceiling.
    int     cfg_fc  [2] = '{1, 3};
    int     cfg_to  [2] = '{1023, 4};
    longint cfg_max [2] = '{64'hFFFF_FFFF, 15};

    int          m_flush_left [2];
    logic [31:0] m_held_pc    [2];
    int          m_run        [2];
    longint      m_perf       [2];

    function automatic logic [31:0] ref_target(input logic [31:0] code, input logic [31:0] ret);
        if (code == 32'h1) return 32'h0000_0020;
        if (code == 32'h8 || code == 32'ha || code == 32'hc || code == 32'hd) return 32'h0000_0040;
        if (code == 32'he) return ret;
        return 32'h0;
    endfunction

    task automatic model_step(input int d, output exp_t e);
        int top;
        e.stall = '0; e.flush = 1'b0; e.pc = '0; e.tmo = 1'b0; e.perf = '0;
        if (rst) begin
            m_flush_left[d] = 0;
            m_held_pc[d]    = '0;
            m_run[d]        = 0;
            m_perf[d]       = 0;
            return;
        end
        e.perf = 32'(m_perf[d]);
        if (m_flush_left[d] > 0) begin
            e.flush = 1'b1;
            e.pc    = m_held_pc[d];
            m_flush_left[d]--;
        end else if (exc != 0) begin
            e.flush         = 1'b1;
            e.pc            = ref_target(exc, epc);
            m_held_pc[d]    = e.pc;
            m_flush_left[d] = cfg_fc[d] - 1;
        end else begin
            top = -1;
            for (int k = 0; k < 6; k++) if (stallreq[k]) top = k;
            if (top >= 0) e.stall = 6'((1 << (top + 1)) - 1);
        end
        if (e.stall != 0) begin
            m_run[d]++;
            e.tmo = (cfg_to[d] != 0) && (m_run[d] == cfg_to[d]);
        end else begin
            m_run[d] = 0;
        end
        if (perf_clr)                                    m_perf[d] = 0;
        else if (e.stall != 0 && m_perf[d] < cfg_max[d]) m_perf[d]++;
    endtask

    // ---------------- stimulus ----------------
    task automatic step(input logic r, input logic [5:0] sr, input logic [31:0] et,
                        input logic [31:0] ep, input logic pclr);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; stallreq = sr; exc = et; epc = ep; perf_clr = pclr;
        model_step(0, e); q0.push_back(e);
        model_step(1, e); q1.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 6'b0, 32'h0, 32'h0, 1'b0);
    endtask

    // ---------------- monitor ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("a.stall", 32'(a_stall), 32'(e.stall));
                chk("a.flush", 32'(a_flush), 32'(e.flush));
                chk("a.new_pc", a_pc, e.pc);
                chk("a.timeout", 32'(a_tmo), 32'(e.tmo));
                chk("a.perf", a_perf, e.perf);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("b.stall", 32'(b_stall), 32'(e.stall));
                chk("b.flush", 32'(b_flush), 32'(e.flush));
                chk("b.new_pc", b_pc, e.pc);
                chk("b.timeout", 32'(b_tmo), 32'(e.tmo));
                chk("b.perf", 32'(b_perf), e.perf);
            end
        end
    end

    logic [31:0] codes [8] = '{32'h1, 32'h8, 32'ha, 32'hc, 32'hd, 32'he, 32'h3, 32'h10};

    initial begin : stimulus
        logic [5:0]  held;
        logic [31:0] et;
        // reset state, then release
        step(1'b1, 6'b0, 32'h0, 32'h0, 1'b0);
        step(1'b1, 6'b111111, 32'h1, 32'h0, 1'b1);
        idle(2);

        // stall masks: ex request, then mem+id requests
        step(1'b0, 6'b001000, 32'h0, 32'h0, 1'b0);
        step(1'b0, 6'b010100, 32'h0, 32'h0, 1'b0);
        step(1'b0, 6'b000001, 32'h0, 32'h0, 1'b0);
        step(1'b0, 6'b100000, 32'h0, 32'h0, 1'b0);
        idle(3);

        // eret overrides a pending stall
        step(1'b0, 6'b010000, 32'he, 32'h0000_1234, 1'b0);
        step(1'b0, 6'b010000, 32'h0, 32'h0000_1234, 1'b0);
        idle(3);

        // interrupt followed by syscall on the next cycle; unknown code
        step(1'b0, 6'b000000, 32'h1, 32'h0, 1'b0);
        step(1'b0, 6'b001000, 32'h8, 32'h0, 1'b0);
        step(1'b0, 6'b001000, 32'h0, 32'h0, 1'b0);
        idle(3);
        step(1'b0, 6'b000000, 32'h7, 32'h55, 1'b0);
        idle(4);

        // stall timeout: 10 cycles, drop one, 4 more
        for (int i = 0; i < 10; i++) step(1'b0, 6'b001000, 32'h0, 32'h0, 1'b0);
        step(1'b0, 6'b000000, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 6'b001000, 32'h0, 32'h0, 1'b0);
        idle(2);

        // perf counter: 5 stalls, clear with stall, 2 stalls, then 20 to saturate the narrow counter
        step(1'b0, 6'b0, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 6'b000100, 32'h0, 32'h0, 1'b0);
        step(1'b0, 6'b000100, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b0, 6'b000100, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 6'b000010, 32'h0, 32'h0, 1'b0);
        idle(3);

        // reset during the 2nd flush cycle
        step(1'b0, 6'b0, 32'hc, 32'h0, 1'b0);
        step(1'b1, 6'b0, 32'h0, 32'h0, 1'b0);
        idle(4);

        // long stall to reach the default 1023-cycle timeout
        for (int i = 0; i < 1030; i++) step(1'b0, 6'b010000, 32'h0, 32'h0, 1'b0);
        idle(2);

        // randomized traffic
        held = 6'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(7) == 0) held = ($urandom_range(3) == 0) ? 6'b0 : 6'($urandom);
            et = ($urandom_range(11) == 0) ? codes[$urandom_range(7)] : 32'h0;
            step(($urandom_range(99) == 0), held, et, $urandom, ($urandom_range(24) == 0));
        end
        idle(3);

        @(negedge clk);
        @(negedge clk);
        chk("queue.a.drained", 32'(q0.size()), 32'd0);
        chk("queue.b.drained", 32'(q1.size()), 32'd0);
        stim_done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
